data_memory_responder: RTL

Responder end of the core's data-memory request interface. Accepts one load or store request at a time from the processor datapath via a valid/ready handshake, performs it against an internal word-addressed byte-enabled store, and returns a response after a fixed programmable latency with response back-pressure. This is the memory side that the processor's load/store path drives; it replaces the zero-latency combinational data memory for multi-cycle configurations.

---
 rtl/ant_mem_pkg.sv | 13 +
 rtl/dmem_array.sv | 33 +++
 rtl/data_memory_responder.sv | 110 +++++++++++
 3 files changed

// File: rtl/ant_mem_pkg.sv
// rtl/ant_mem_pkg.sv - shared types and widths for the data-memory responder
package ant_mem_pkg;

    localparam int WORD_W = 32;
    localparam int STRB_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_t;

endpackage

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port byte-enabled RAM with registered read-before-write data
module dmem_array
    import ant_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clock_i,
    input  logic              en_i,
    input  logic [STRB_W-1:0] we_i,
    input  logic [IDX_W-1:0]  addr_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [WORD_W-1:0] rdata_o
);

    logic [WORD_W-1:0] mem_q [DEPTH_WORDS];
    logic [WORD_W-1:0] rdata_q;

    // Read data holds its value until the next enabled access.
    always_ff @(posedge clock_i) begin
        if (en_i) begin
            rdata_q <= mem_q[addr_i];
            for (int b = 0; b < STRB_W; b++) begin
                if (we_i[b]) begin
                    mem_q[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
                end
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_memory_responder.sv
// rtl/data_memory_responder.sv - load/store responder with programmable latency; DMEM_FAULT_CHECK_EN enables fault reporting
module data_memory_responder
    import ant_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [WORD_W-1:0] req_wdata,
    input  logic [STRB_W-1:0] req_wstrb,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [WORD_W-1:0] resp_rdata,
    output logic              resp_err
);

    localparam int         IDX_W  = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    dmem_state_t       state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              rd_sel_q, rd_sel_d;
    logic              accept;
    logic              fault;
    logic [IDX_W-1:0]  idx;
    logic [STRB_W-1:0] we;
    logic [WORD_W-1:0] ram_rdata;

    assign idx = req_addr[IDX_W+1:2];

`ifdef DMEM_FAULT_CHECK_EN
    assign fault = (req_addr[1:0] != 2'b00) || ((req_addr >> (IDX_W + 2)) != 32'd0);
`else
    logic unused_addr_bits;
    assign unused_addr_bits = ^{req_addr[31:IDX_W+2], req_addr[1:0]};
    assign fault = 1'b0;
`endif

    // Held low while reset is asserted so no request slips in during reset.
    assign req_ready = reset && (state_q == IDLE);
    assign accept    = req_valid && req_ready;
    assign we        = (accept && req_write && !fault) ? req_wstrb : '0;

    dmem_array #(
        .DEPTH_WORDS(DEPTH_WORDS),
        .IDX_W      (IDX_W)
    ) u_array (
        .clock_i(clock),
        .en_i   (accept),
        .we_i   (we),
        .addr_i (idx),
        .wdata_i(req_wdata),
        .rdata_o(ram_rdata)
    );

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        rd_sel_d = rd_sel_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    cnt_d    = LAT_M1;
                    err_d    = fault;
                    rd_sel_d = !req_write && !fault;
                    state_d  = (LATENCY == 1) ? RESP : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (resp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q  <= IDLE;
            cnt_q    <= 4'd0;
            err_q    <= 1'b0;
            rd_sel_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            rd_sel_q <= rd_sel_d;
        end
    end

    // The RAM read register doubles as the response data register.
    assign resp_valid = (state_q == RESP);
    assign resp_err   = err_q;
    assign resp_rdata = rd_sel_q ? ram_rdata : '0;

endmodule
